// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX controller among NUM_REQ byte producers.
// Latches the granted byte, pulses start for one cycle and holds the byte until done or watchdog abort.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned GAP_CYCLES     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [2:0]           o_Grant_Id,
  output logic [7:0]           o_Tx_Byte,
  output logic                 o_Tx_Start,
  input  logic                 i_Tx_Done,
  input  logic                 i_Tx_Active,
  input  logic                 i_Clear_Err,
  output logic                 o_Busy,
  output logic                 o_Timeout_Err,
  output logic [15:0]          o_Frame_Count
);

  localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]      GAP_N    = 4'(GAP_CYCLES);
  localparam logic [3:0]      NREQ4    = 4'(NUM_REQ);
  localparam logic [2:0]      LAST_REQ = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t           r_State, w_Next;
  logic [2:0]       r_Ptr, r_Grant;
  logic [7:0]       r_Tx_Byte;
  logic [WD_W-1:0]  r_Wdog;
  logic [3:0]       r_Gap;
  logic             r_Err;
  logic [15:0]      r_Frame_Count;

  logic [NUM_REQ-1:0] w_Rot;
  logic               w_Any;
  logic [2:0]         w_Off, w_Win, w_Ptr_Next;
  logic [3:0]         w_Sum;
  logic [7:0]         w_Win_Byte;
  logic               w_Grant, w_Done, w_Timeout;
  logic               w_unused_tx_active;

  assign w_unused_tx_active = i_Tx_Active;

  // Rotate valids so bit 0 is the pointer position; first set bit is the winner offset.
  always_comb begin
    w_Rot = NUM_REQ'({i_Req_Valid, i_Req_Valid} >> r_Ptr);
    w_Any = 1'b0;
    w_Off = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!w_Any && w_Rot[j]) begin
        w_Any = 1'b1;
        w_Off = 3'(j);
      end
    end
    w_Sum      = {1'b0, r_Ptr} + {1'b0, w_Off};
    w_Win      = (w_Sum >= NREQ4) ? 3'(w_Sum - NREQ4) : w_Sum[2:0];
    w_Ptr_Next = (w_Win == LAST_REQ) ? 3'd0 : w_Win + 3'd1;
    w_Win_Byte = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (w_Win == 3'(j)) w_Win_Byte = i_Req_Byte[8*j +: 8];
    end
  end

  always_comb begin
    w_Next    = r_State;
    w_Grant   = 1'b0;
    w_Done    = 1'b0;
    w_Timeout = 1'b0;
    case (r_State)
      IDLE: begin
        if (w_Any) begin
          w_Grant = 1'b1;
          w_Next  = ISSUE;
        end
      end
      ISSUE: w_Next = WAIT_DONE;
      WAIT_DONE: begin
        // Done takes priority over a watchdog expiring in the same cycle.
        if (i_Tx_Done) begin
          w_Done = 1'b1;
          w_Next = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else if (r_Wdog == WD_MAX) begin
          w_Timeout = 1'b1;
          w_Next    = IDLE;
        end
      end
      GAP: begin
        if (r_Gap == GAP_N) w_Next = IDLE;
      end
      default: w_Next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_State       <= IDLE;
      r_Ptr         <= '0;
      r_Grant       <= '0;
      r_Tx_Byte     <= '0;
      r_Wdog        <= '0;
      r_Gap         <= '0;
      r_Err         <= 1'b0;
      r_Frame_Count <= '0;
    end else begin
      r_State <= w_Next;
      if (w_Grant) begin
        r_Tx_Byte <= w_Win_Byte;
        r_Grant   <= w_Win;
        r_Ptr     <= w_Ptr_Next;
      end
      if (r_State == ISSUE) begin
        r_Wdog <= WD_W'(1);
      end else if (r_State == WAIT_DONE && !w_Done && !w_Timeout) begin
        r_Wdog <= r_Wdog + 1'b1;
      end
      if (w_Done) begin
        r_Gap <= 4'd1;
      end else if (r_State == GAP) begin
        r_Gap <= r_Gap + 4'd1;
      end
      if (w_Done) r_Frame_Count <= r_Frame_Count + 16'd1;
      if (w_Timeout) begin
        r_Err <= 1'b1;
      end else if (i_Clear_Err) begin
        r_Err <= 1'b0;
      end
    end
  end

  always_comb begin
    o_Req_Ready = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      o_Req_Ready[j] = (r_State == ISSUE) && (r_Grant == 3'(j));
    end
  end

  assign o_Tx_Start    = (r_State == ISSUE);
  assign o_Busy        = (r_State != IDLE);
  assign o_Grant_Id    = r_Grant;
  assign o_Tx_Byte     = r_Tx_Byte;
  assign o_Timeout_Err = r_Err;
  assign o_Frame_Count = r_Frame_Count;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx_controller among NUM_REQ byte producers using round-robin arbitration.
- Accepts one byte per grant through a valid/ready handshake and latches it.
- Issues a single-cycle start pulse to the TX controller, holds the byte stable for the whole frame, and waits for the controller's done pulse before granting again.
- Runs on the same baud-tick clock as the TX controller. Adds a frame watchdog, a sticky timeout flag and a sent-frame counter.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 32: cycles allowed in WAIT_DONE before abort. Must be >= 12; a frame takes 11 cycles from start pulse to done.
- GAP_CYCLES, 1: idle-line cycles inserted after each frame, 0..15.

Ports:
- clk  in  1  baud-tick clock, shared with uart_tx_controller.
- reset  in  1  synchronous, active-high reset.
- i_Req_Valid  in  NUM_REQ  per-requester byte valid.
- i_Req_Byte  in  8*NUM_REQ  requester r byte at bits [8r+7:8r].
- o_Req_Ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- o_Grant_Id  out  3  index of the requester owning the current frame.
- o_Tx_Byte  out  8  to controller i_Tx_Byte.
- o_Tx_Start  out  1  to controller i_Tx_Ready.
- i_Tx_Done  in  1  from controller o_Tx_Done.
- i_Tx_Active  in  1  from controller o_Tx_Active; status only, not used for sequencing.
- i_Clear_Err  in  1  clears o_Timeout_Err.
- o_Busy  out  1  high in any state other than IDLE.
- o_Timeout_Err  out  1  sticky watchdog flag.
- o_Frame_Count  out  16  frames completed with done, wraps 0xFFFF->0.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All outputs are registered or Moore-decoded from state.
- Reset values: state=IDLE, o_Req_Ready=0, o_Grant_Id=0, o_Tx_Byte=0, o_Tx_Start=0, o_Busy=0, o_Timeout_Err=0, o_Frame_Count=0, RR pointer=0, counters=0.
- Reset mid-frame aborts immediately to IDLE with no ready or start pulse. The controller's own reset is tied at top level.
- FSM IDLE:
  - If any i_Req_Valid is high at the edge, pick winner w = first set bit searching ptr, ptr+1, ... modulo NUM_REQ.
  - Latch i_Req_Byte[w] into o_Tx_Byte and w into o_Grant_Id; set ptr=(w+1) mod NUM_REQ; go to ISSUE.
  - If no valid is high, remain in IDLE.
- FSM ISSUE (exactly 1 cycle):
  - o_Tx_Start=1 and o_Req_Ready[w]=1 during this cycle; go to WAIT_DONE.
  - The requester treats the byte as consumed at the edge ending this cycle and may then present its next byte or drop valid.
- FSM WAIT_DONE:
  - o_Tx_Byte is held constant. The controller reads bits live during DATA, so this is mandatory.
  - Watchdog counts from 1.
  - i_Tx_Done=1: o_Frame_Count+1; go to GAP if GAP_CYCLES>0, else IDLE.
  - Watchdog reaches TIMEOUT_CYCLES without done: set o_Timeout_Err, do not increment the count, go to IDLE.
  - Done and timeout in the same cycle: done wins, no error.
- FSM GAP: hold o_Tx_Start=0 for GAP_CYCLES cycles, then go to IDLE.
- Latency: valid high at IDLE edge k -> start and ready pulse in cycle k+1 -> controller START at edge k+2.
  - Back-to-back frame period with GAP_CYCLES=G is 13+G cycles.
- Fairness: a requester holding valid continuously waits at most NUM_REQ-1 frames. The pointer advances only on grant.
- Valid is sampled only in IDLE. Valid dropped before a grant is legal and ignored; i_Req_Byte changes while not granted are ignored.
- o_Tx_Start is never high outside ISSUE, so holding i_Tx_Ready high cannot retrigger the controller.
- i_Clear_Err=1 clears the flag. If a timeout occurs in the same cycle, set wins.
- i_Tx_Done seen outside WAIT_DONE is ignored.

Test Plan:
- Single requester: reset, req0 valid with 0xA5 -> ready[0] and start high for exactly 1 cycle. TX line shows 0, then 1,0,1,0,0,1,0,1, then 1. o_Frame_Count=1. o_Tx_Byte holds 0xA5 until done.
- Round-robin: all 4 requesters hold valid with 0x10,0x21,0x32,0x43 -> grant order 0,1,2,3,0. Each ready pulse is one-hot. Frame starts are 14 cycles apart with GAP_CYCLES=1.
- Pointer wrap: ptr=3, only req1 and req3 valid -> req3 granted first, then req1. o_Grant_Id follows 3,1.
- Watchdog: i_Tx_Done forced low -> o_Timeout_Err rises after 32 WAIT_DONE cycles, state returns to IDLE, count unchanged. i_Clear_Err pulse clears the flag; a simultaneous timeout keeps it set.
- Reset mid-frame: assert reset during WAIT_DONE at bit 4 -> next cycle all outputs at reset values, ptr=0. After release, a pending req2 is granted first.
- Counter wrap: preload via 65535 frames, or a force in the bench -> the next done sets o_Frame_Count=0x0000.
